mcu_cmd_mc: RTL and testbench

Multi-channel successor to the MCU SPI command decoder. It interprets command and parameter bytes from the SPI slave. It holds NCH independent address pointers, each with a programmable wrap mask. It issues single-cycle read and write requests against the MCU memory port, with auto-increment, and adds pending-request tracking and a sticky collision error. It sits between the SPI slave and the memory arbiter, in place of the fixed ROM/DAC/MSU address registers.

---
 rtl/mcu_cmd_mc.sv | 196 +++++++++++++++++++
 tb/tb_mcu_cmd_mc.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_cmd_mc.sv
// mcu_cmd_mc: multi-channel SPI command decoder with per-channel address
// pointers, programmable wrap masks, single-outstanding memory requests,
// pending tracking and a sticky collision error.
module mcu_cmd_mc #(
    parameter int unsigned NCH = 4,
    parameter int unsigned AW  = 24,
    parameter int unsigned CW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_ready,
    input  logic              param_ready,
    input  logic [7:0]        cmd_data,
    input  logic [7:0]        param_data,
    output logic [7:0]        spi_data_out,
    output logic              mcu_rrq,
    output logic              mcu_wrq,
    input  logic              mcu_rq_rdy,
    input  logic [7:0]        mcu_data_in,
    output logic [7:0]        mcu_data_out,
    output logic [AW-1:0]     mcu_addr_out,
    output logic [CW-1:0]     dma_tgt_out,
    input  logic              dma_nextaddr,
    output logic [NCH*AW-1:0] chan_addr_out
);

    localparam int unsigned AB = (AW + 7) / 8;
    localparam int unsigned BW = AB * 8;

    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

    state_t        state;
    logic [7:0]    cmd_q;
    logic [7:0]    idx_q;
    logic [AW-1:0] ptr_q  [NCH];
    logic [AW-1:0] mask_q [NCH];
    logic [2:0]    req_ch;
    logic          req_inc;
    logic          err;
    logic          rdy_prev;

    logic [7:0]    cur_cmd;
    logic [3:0]    op;
    logic [2:0]    ch;
    logic          inc;
    logic          ch_ok;
    logic          strobe;
    logic          pstrobe;
    logic          rd_issue;
    logic          wr_issue;
    logic          rd_bad;
    logic          ptr_wr;
    logic          mask_wr;
    logic          pending;
    logic          done;
    logic [AW-1:0] sel_ptr;
    logic [AW-1:0] ptr_d  [NCH];
    logic [AW-1:0] mask_d [NCH];

    // Big-endian byte load: byte 0 is the most significant and clears the rest
    function automatic logic [AW-1:0] byte_merge(input logic [AW-1:0] old,
                                                 input logic [7:0]    idx,
                                                 input logic [7:0]    b);
        logic [BW-1:0] w;
        int unsigned   sh;
        sh = (AB - 1 - 32'(idx)) * 8;
        w  = (idx == 8'd0) ? '0 : BW'(old);
        w  = w & ~(BW'(8'hFF) << sh);
        w  = w | (BW'(b) << sh);
        return AW'(w);
    endfunction

    // Command decode; a fresh cmd_ready byte takes effect in its own cycle
    always_comb begin
        cur_cmd  = cmd_ready ? cmd_data : cmd_q;
        op       = cur_cmd[7:4];
        inc      = cur_cmd[3];
        ch       = cur_cmd[2:0];
        ch_ok    = 32'(ch) < NCH;
        strobe   = cmd_ready | param_ready;
        pstrobe  = param_ready & ~cmd_ready;
        rd_issue = strobe & ch_ok & (op == 4'h8);
        wr_issue = pstrobe & ch_ok & (op == 4'h9);
        rd_bad   = strobe & ~ch_ok & (op == 4'h8);
        ptr_wr   = pstrobe & ch_ok & (op == 4'h0) & (32'(idx_q) < AB);
        mask_wr  = pstrobe & ch_ok & (op == 4'h1) & (32'(idx_q) < AB);
        pending  = (state != IDLE);
        done     = mcu_rq_rdy & ~rdy_prev & pending;
    end

    // Per-channel next pointer/mask: masked increments, parameter writes win
    always_comb begin
        logic [1:0] cnt;
        sel_ptr = '0;
        cnt     = 2'd0;
        for (int unsigned c = 0; c < NCH; c++) begin
            cnt = 2'd0;
            if (done && req_inc && (req_ch == 3'(c)))
                cnt = cnt + 2'd1;
            if (dma_nextaddr && (dma_tgt_out == CW'(c)))
                cnt = cnt + 2'd1;
            ptr_d[c]  = (ptr_q[c] & ~mask_q[c]) | ((ptr_q[c] + AW'(cnt)) & mask_q[c]);
            mask_d[c] = mask_q[c];
            if (ch == 3'(c))
                sel_ptr = ptr_q[c];
            if (ptr_wr && (ch == 3'(c)))
                ptr_d[c] = byte_merge(ptr_q[c], idx_q, param_data);
            if (mask_wr && (ch == 3'(c)))
                mask_d[c] = byte_merge(mask_q[c], idx_q, param_data);
        end
    end

    // Flattened pointer view, channel 0 in the LSBs
    always_comb begin
        chan_addr_out = '0;
        for (int unsigned c = 0; c < NCH; c++)
            chan_addr_out[c*AW +: AW] = ptr_q[c];
    end

    // Request FSM, byte tracking, pointer/mask state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cmd_q        <= '0;
            idx_q        <= '0;
            req_ch       <= '0;
            req_inc      <= 1'b0;
            err          <= 1'b0;
            rdy_prev     <= 1'b1;
            spi_data_out <= '0;
            mcu_rrq      <= 1'b0;
            mcu_wrq      <= 1'b0;
            mcu_data_out <= '0;
            mcu_addr_out <= '0;
            dma_tgt_out  <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                ptr_q[c]  <= '0;
                mask_q[c] <= '1;
            end
        end else begin
            rdy_prev <= mcu_rq_rdy;
            mcu_rrq  <= 1'b0;
            mcu_wrq  <= 1'b0;
            for (int unsigned c = 0; c < NCH; c++) begin
                ptr_q[c]  <= ptr_d[c];
                mask_q[c] <= mask_d[c];
            end

            if (cmd_ready) begin
                cmd_q <= cmd_data;
                idx_q <= 8'd0;
            end else if (param_ready && (idx_q != 8'hFF)) begin
                idx_q <= idx_q + 8'd1;
            end

            if (done) begin
                if (state == RD_WAIT)
                    spi_data_out <= mcu_data_in;
                state <= IDLE;
            end

            if (rd_issue || wr_issue) begin
                if (state == IDLE) begin
                    mcu_addr_out <= sel_ptr;
                    req_ch       <= ch;
                    req_inc      <= inc;
                    if (rd_issue) begin
                        mcu_rrq <= 1'b1;
                        state   <= RD_WAIT;
                    end else begin
                        mcu_wrq      <= 1'b1;
                        mcu_data_out <= param_data;
                        state        <= WR_WAIT;
                    end
                end else begin
                    err <= 1'b1;
                end
            end

            if (cmd_ready && (op == 4'h4) && ch_ok)
                dma_tgt_out <= CW'(ch);

            if (rd_bad)
                spi_data_out <= 8'hFF;

            if (strobe && (cur_cmd == 8'hF0))
                spi_data_out <= 8'hA5;

            if (strobe && (cur_cmd == 8'hF1)) begin
                spi_data_out <= {pending, err, 3'b000, 3'(dma_tgt_out)};
                err          <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mcu_cmd_mc.sv
// Testbench for mcu_cmd_mc: directed vector table, corner-case sequences and
// randomized traffic against a transaction-level reference model.
module tb_mcu_cmd_mc;

    localparam int unsigned NCH = 4;
    localparam int unsigned AW  = 24;
    localparam int unsigned CW  = 3;
    localparam int unsigned AB  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_ready;
    logic              param_ready;
    logic [7:0]        cmd_data;
    logic [7:0]        param_data;
    logic [7:0]        spi_data_out;
    logic              mcu_rrq;
    logic              mcu_wrq;
    logic              mcu_rq_rdy;
    logic [7:0]        mcu_data_in;
    logic [7:0]        mcu_data_out;
    logic [AW-1:0]     mcu_addr_out;
    logic [CW-1:0]     dma_tgt_out;
    logic              dma_nextaddr;
    logic [NCH*AW-1:0] chan_addr_out;

    mcu_cmd_mc #(.NCH(NCH), .AW(AW), .CW(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_ready     (cmd_ready),
        .param_ready   (param_ready),
        .cmd_data      (cmd_data),
        .param_data    (param_data),
        .spi_data_out  (spi_data_out),
        .mcu_rrq       (mcu_rrq),
        .mcu_wrq       (mcu_wrq),
        .mcu_rq_rdy    (mcu_rq_rdy),
        .mcu_data_in   (mcu_data_in),
        .mcu_data_out  (mcu_data_out),
        .mcu_addr_out  (mcu_addr_out),
        .dma_tgt_out   (dma_tgt_out),
        .dma_nextaddr  (dma_nextaddr),
        .chan_addr_out (chan_addr_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state (0 = no request, 1 = read, 2 = write outstanding)
    logic [AW-1:0] m_ptr  [NCH];
    logic [AW-1:0] m_mask [NCH];
    logic [CW-1:0] m_tgt;
    logic [7:0]    m_spi, m_dout, m_cmd, m_idx;
    logic [AW-1:0] m_addr;
    logic          m_rrq, m_wrq, m_err, m_prev, m_req_inc;
    int            m_busy, m_req_ch;

    typedef struct {
        logic       cr;
        logic       pr;
        logic [7:0] cmd;
        logic [7:0] prm;
        logic       rdy;
        logic [7:0] din;
        logic       e_rrq;
        logic [23:0] e_addr;
        logic [7:0] e_spi;
        logic [23:0] e_p2;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic cr, input logic pr, input logic [7:0] cmd,
                                input logic [7:0] prm, input logic rdy, input logic [7:0] din,
                                input logic e_rrq, input logic [23:0] e_addr,
                                input logic [7:0] e_spi, input logic [23:0] e_p2);
        vec_t v;
        v.cr = cr; v.pr = pr; v.cmd = cmd; v.prm = prm; v.rdy = rdy; v.din = din;
        v.e_rrq = e_rrq; v.e_addr = e_addr; v.e_spi = e_spi; v.e_p2 = e_p2;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Big-endian load of byte idx into a pointer/mask word
    function automatic logic [AW-1:0] put_byte(input logic [AW-1:0] old, input int idx,
                                               input logic [7:0] b);
        logic [31:0] w;
        int          sh;
        sh = 8 * (int'(AB) - 1 - idx);
        w  = (idx == 0) ? 32'd0 : 32'(old);
        w  = (w & ~(32'hFF << sh)) | (32'(b) << sh);
        return AW'(w);
    endfunction

    // Advance by n inside the mask field, freezing bits outside it
    function automatic logic [AW-1:0] adv(input logic [AW-1:0] p, input logic [AW-1:0] m,
                                          input int n);
        logic [AW-1:0] s;
        s = p + AW'(n);
        return (p & ~m) | (s & m);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_ptr[c]  = '0;
            m_mask[c] = '1;
        end
        m_tgt = '0; m_spi = '0; m_dout = '0; m_cmd = '0; m_idx = '0; m_addr = '0;
        m_rrq = 1'b0; m_wrq = 1'b0; m_err = 1'b0; m_prev = 1'b1; m_req_inc = 1'b0;
        m_busy = 0; m_req_ch = 0;
    endtask

    // One clock of the model given the inputs presented for that clock
    task automatic model_step(input logic cr, input logic pr, input logic [7:0] c,
                              input logic [7:0] p, input logic rdy, input logic dma,
                              input logic [7:0] din);
        int            busy0, ch, wr_ch, mw_ch;
        int            n [NCH];
        logic          rise;
        logic [7:0]    cc;
        logic [3:0]    op;
        logic [AW-1:0] wr_val, mw_val;
        busy0  = m_busy;
        rise   = rdy && !m_prev;
        m_prev = rdy;
        m_rrq  = 1'b0;
        m_wrq  = 1'b0;
        wr_ch  = -1;
        mw_ch  = -1;
        wr_val = '0;
        mw_val = '0;
        for (int k = 0; k < NCH; k++) n[k] = 0;
        if (rise && busy0 != 0) begin
            if (busy0 == 1) m_spi = din;
            if (m_req_inc) n[m_req_ch]++;
            m_busy = 0;
        end
        if (dma) n[int'(m_tgt)]++;
        if (cr || pr) begin
            cc = cr ? c : m_cmd;
            op = cc[7:4];
            ch = int'(cc[2:0]);
            if (op == 4'h8 || (op == 4'h9 && !cr)) begin
                if (ch >= NCH) begin
                    if (op == 4'h8) m_spi = 8'hFF;
                end else if (busy0 != 0) begin
                    m_err = 1'b1;
                end else begin
                    m_addr    = m_ptr[ch];
                    m_req_ch  = ch;
                    m_req_inc = cc[3];
                    if (op == 4'h8) begin
                        m_rrq  = 1'b1;
                        m_busy = 1;
                    end else begin
                        m_wrq  = 1'b1;
                        m_dout = p;
                        m_busy = 2;
                    end
                end
            end
            if (cr && op == 4'h4 && ch < NCH) m_tgt = CW'(ch);
            if (!cr && ch < NCH && int'(m_idx) < AB) begin
                if (op == 4'h0) begin
                    wr_ch  = ch;
                    wr_val = put_byte(m_ptr[ch], int'(m_idx), p);
                end
                if (op == 4'h1) begin
                    mw_ch  = ch;
                    mw_val = put_byte(m_mask[ch], int'(m_idx), p);
                end
            end
            if (cc == 8'hF0) m_spi = 8'hA5;
            if (cc == 8'hF1) begin
                m_spi = {(busy0 != 0), m_err, 3'b000, 3'(m_tgt)};
                m_err = 1'b0;
            end
            if (cr) begin
                m_cmd = c;
                m_idx = 8'd0;
            end else if (m_idx != 8'hFF) begin
                m_idx = m_idx + 8'd1;
            end
        end
        for (int k = 0; k < NCH; k++) begin
            if (k == wr_ch) m_ptr[k] = wr_val;
            else            m_ptr[k] = adv(m_ptr[k], m_mask[k], n[k]);
            if (k == mw_ch) m_mask[k] = mw_val;
        end
    endtask

    task automatic check_model();
        logic [NCH*AW-1:0] e;
        e = '0;
        for (int k = 0; k < NCH; k++) e[k*AW +: AW] = m_ptr[k];
        chk("spi_data_out", 128'(spi_data_out), 128'(m_spi));
        chk("mcu_rrq", 128'(mcu_rrq), 128'(m_rrq));
        chk("mcu_wrq", 128'(mcu_wrq), 128'(m_wrq));
        chk("mcu_data_out", 128'(mcu_data_out), 128'(m_dout));
        chk("mcu_addr_out", 128'(mcu_addr_out), 128'(m_addr));
        chk("dma_tgt_out", 128'(dma_tgt_out), 128'(m_tgt));
        chk("chan_addr_out", 128'(chan_addr_out), 128'(e));
    endtask

    task automatic step(input logic cr, input logic pr, input logic [7:0] c,
                        input logic [7:0] p, input logic rdy, input logic dma,
                        input logic [7:0] din);
        cmd_ready    = cr;
        param_ready  = pr;
        cmd_data     = c;
        param_data   = p;
        mcu_rq_rdy   = rdy;
        dma_nextaddr = dma;
        mcu_data_in  = din;
        model_step(cr, pr, c, p, rdy, dma, din);
        @(posedge clk);
        #1;
        cmd_ready    = 1'b0;
        param_ready  = 1'b0;
        dma_nextaddr = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        cmd_ready    = 1'b0;
        param_ready  = 1'b0;
        dma_nextaddr = 1'b0;
        mcu_rq_rdy   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    logic       r_rdy, r_dma, r_cr, r_pr;
    logic [7:0] r_c, r_p, r_din;
    int         kind, sel;

    initial begin
        cmd_data    = '0;
        param_data  = '0;
        mcu_data_in = '0;
        do_reset();

        // Reset state
        chk("rst spi", 128'(spi_data_out), 128'h0);
        chk("rst rrq_wrq", 128'({mcu_rrq, mcu_wrq}), 128'h0);
        chk("rst addr", 128'(mcu_addr_out), 128'h0);
        chk("rst dout", 128'(mcu_data_out), 128'h0);
        chk("rst tgt", 128'(dma_tgt_out), 128'h0);
        chk("rst chan", 128'(chan_addr_out), 128'h0);

        // Pointer/mask load on channel 2 then a wrapping auto-increment read stream
        tbl[0]  = mk(1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h000000);
        tbl[1]  = mk(1'b0, 1'b1, 8'h00, 8'h12, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h120000);
        tbl[2]  = mk(1'b0, 1'b1, 8'h00, 8'h34, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h123400);
        tbl[3]  = mk(1'b0, 1'b1, 8'h00, 8'h56, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h123456);
        tbl[4]  = mk(1'b1, 1'b0, 8'h12, 8'h00, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h123456);
        tbl[5]  = mk(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h123456);
        tbl[6]  = mk(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h123456);
        tbl[7]  = mk(1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h123456);
        tbl[8]  = mk(1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h123456);
        tbl[9]  = mk(1'b0, 1'b1, 8'h00, 8'h12, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h120000);
        tbl[10] = mk(1'b0, 1'b1, 8'h00, 8'h34, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h123400);
        tbl[11] = mk(1'b0, 1'b1, 8'h00, 8'hFE, 1'b0, 8'h00, 1'b0, 24'h000000, 8'h00, 24'h1234FE);
        tbl[12] = mk(1'b1, 1'b0, 8'h8A, 8'h00, 1'b0, 8'h00, 1'b1, 24'h1234FE, 8'h00, 24'h1234FE);
        tbl[13] = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h11, 1'b0, 24'h1234FE, 8'h11, 24'h1234FF);
        tbl[14] = mk(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 24'h1234FF, 8'h11, 24'h1234FF);
        tbl[15] = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h22, 1'b0, 24'h1234FF, 8'h22, 24'h123400);
        tbl[16] = mk(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 24'h123400, 8'h22, 24'h123400);
        tbl[17] = mk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h33, 1'b0, 24'h123400, 8'h33, 24'h123401);
        tbl[18] = mk(1'b1, 1'b0, 8'hF0, 8'h00, 1'b0, 8'h00, 1'b0, 24'h123400, 8'hA5, 24'h123401);
        tbl[19] = mk(1'b1, 1'b0, 8'hF1, 8'h00, 1'b0, 8'h00, 1'b0, 24'h123400, 8'h00, 24'h123401);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].cr, tbl[i].pr, tbl[i].cmd, tbl[i].prm, tbl[i].rdy, 1'b0, tbl[i].din);
            chk($sformatf("tbl%0d rrq", i), 128'(mcu_rrq), 128'(tbl[i].e_rrq));
            chk($sformatf("tbl%0d addr", i), 128'(mcu_addr_out), 128'(tbl[i].e_addr));
            chk($sformatf("tbl%0d spi", i), 128'(spi_data_out), 128'(tbl[i].e_spi));
            chk($sformatf("tbl%0d ptr2", i), 128'(chan_addr_out[2*AW +: AW]), 128'(tbl[i].e_p2));
        end

        // Write collision: second write dropped, sticky err, cleared by status read
        step(1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("coll tgt", 128'(dma_tgt_out), 128'h1);
        step(1'b1, 1'b0, 8'h99, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'hAA, 1'b0, 1'b0, 8'h00);
        chk("coll wrq1", 128'(mcu_wrq), 128'h1);
        chk("coll dout1", 128'(mcu_data_out), 128'hAA);
        step(1'b0, 1'b1, 8'h00, 8'hBB, 1'b0, 1'b0, 8'h00);
        chk("coll wrq2", 128'(mcu_wrq), 128'h0);
        chk("coll dout2", 128'(mcu_data_out), 128'hAA);
        step(1'b1, 1'b0, 8'hF1, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("coll status", 128'(spi_data_out), 128'hC1);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("coll wr inc", 128'(chan_addr_out[1*AW +: AW]), 128'h000001);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'hF1, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("coll status2", 128'(spi_data_out), 128'h01);

        // DMA increment and read completion increment land on the same channel together
        step(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h89, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("dual rrq", 128'(mcu_rrq), 128'h1);
        chk("dual addr", 128'(mcu_addr_out), 128'h000010);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h5A);
        chk("dual ptr1", 128'(chan_addr_out[1*AW +: AW]), 128'h000012);
        chk("dual spi", 128'(spi_data_out), 128'h5A);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);

        // Out-of-range channel: no pointer change, read returns 0xFF without a request
        step(1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h22, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h00, 8'h33, 1'b0, 1'b0, 8'h00);
        chk("badch chan", 128'(chan_addr_out), 128'({24'h0, 24'h123401, 24'h000012, 24'h0}));
        step(1'b1, 1'b0, 8'h87, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("badch rrq", 128'(mcu_rrq), 128'h0);
        chk("badch spi", 128'(spi_data_out), 128'hFF);

        // Reset while a read is outstanding; the late completion must be ignored
        step(1'b1, 1'b0, 8'h88, 8'h00, 1'b0, 1'b0, 8'h00);
        chk("rstmid rrq", 128'(mcu_rrq), 128'h1);
        do_reset();
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h77);
        chk("rstmid spi", 128'(spi_data_out), 128'h00);
        chk("rstmid chan", 128'(chan_addr_out), 128'h0);
        step(1'b1, 1'b0, 8'hF1, 8'h00, 1'b1, 1'b0, 8'h00);
        chk("rstmid status", 128'(spi_data_out), 128'h00);

        // Randomized traffic against the model
        do_reset();
        r_rdy = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0) r_rdy = ~r_rdy;
            r_dma = ($urandom_range(0, 7) == 0);
            r_din = 8'($urandom);
            r_p   = 8'($urandom);
            kind  = $urandom_range(0, 3);
            if (r_rdy && !m_prev) kind = 0;
            sel   = $urandom_range(0, 6);
            case (sel)
                0: r_c = {4'h0, 1'($urandom), 3'($urandom)};
                1: r_c = {4'h1, 1'($urandom), 3'($urandom)};
                2: r_c = {4'h4, 1'($urandom), 3'($urandom)};
                3: r_c = {4'h8, 1'($urandom), 3'($urandom)};
                4: r_c = {4'h9, 1'($urandom), 3'($urandom)};
                5: r_c = ($urandom_range(0, 1) == 0) ? 8'hF0 : 8'hF1;
                default: r_c = 8'($urandom);
            endcase
            r_cr = (kind == 1);
            r_pr = (kind >= 2);
            step(r_cr, r_pr, r_c, r_p, r_rdy, r_dma, r_din);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
